// File: rtl/uart_rx_if.sv
// CPU-side register view of the UART receiver: read/clear strobes in,
// FIFO head and status flags out.
interface uart_rx_if #(
  parameter int AW = 2
);
  logic          re;
  logic          clr;
  logic [7:0]    rdata;
  logic          valid;
  logic [AW:0]   count;
  logic          overrun;
  logic          frame_err;

  // CPU / bus side
  modport master (
    output re, clr,
    input  rdata, valid, count, overrun, frame_err
  );

  // receiver side
  modport slave (
    input  re, clr,
    output rdata, valid, count, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The serial line is synchronised, frames are recovered
// by mid-bit sampling against a bit timer, and good bytes are queued in a
// 2**AW entry FIFO that the CPU drains with a read strobe.
module uart_rx #(
  parameter int CLKDIV = 434,
  parameter int AW     = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     rx,
  uart_rx_if.slave bus
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [15:0] HALF_LD  = 16'(CLKDIV / 2 - 1);
  localparam logic [15:0] FULL_LD  = 16'(CLKDIV - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          rx_meta, rxs;
  logic [15:0]   tmr;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;

  logic          tmr_zero;
  logic          ld_half, ld_full, shift_en, bit_clr;
  logic          push, ferr_set;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_n;
  logic          valid_q, overrun_q, frame_err_q;
  logic          pop_ok, wr_en, drop;

  assign tmr_zero = (tmr == 16'd0);

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Frame sequencing: each non-idle state waits for the timer to expire,
  // then samples rxs and decides where to go.
  always_comb begin
    state_n  = state;
    ld_half  = 1'b0;
    ld_full  = 1'b0;
    shift_en = 1'b0;
    bit_clr  = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          ld_half = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tmr_zero) begin
          if (rxs) begin
            // glitch shorter than half a bit: nothing recorded
            state_n = S_IDLE;
          end else begin
            ld_full = 1'b1;
            bit_clr = 1'b1;
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tmr_zero) begin
          shift_en = 1'b1;
          ld_full  = 1'b1;
          if (bitcnt == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tmr_zero) begin
          if (rxs) push     = 1'b1;
          else     ferr_set = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bit timer: half-bit load centres the sampling, full-bit reloads step it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              tmr <= 16'd0;
    else if (ld_half)                          tmr <= HALF_LD;
    else if (ld_full)                          tmr <= FULL_LD;
    else if (state != S_IDLE && !tmr_zero)     tmr <= tmr - 16'd1;
  end

  // Bit counter and LSB-first shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt <= 3'd0;
      shreg  <= 8'h00;
    end else begin
      if (bit_clr)       bitcnt <= 3'd0;
      else if (shift_en) bitcnt <= bitcnt + 3'd1;
      if (shift_en)      shreg  <= {rxs, shreg[7:1]};
    end
  end

  // A pop from empty is ignored, so a simultaneous push into an empty FIFO
  // just writes. When full, a concurrent pop frees the slot for the push.
  assign pop_ok = bus.re && (count != '0);
  assign wr_en  = push && (pop_ok || count != FULL_CNT);
  assign drop   = push && !wr_en;

  // Next occupancy.
  always_comb begin
    count_n = count;
    if (wr_en && !pop_ok)      count_n = count + 1'b1;
    else if (pop_ok && !wr_en) count_n = count - 1'b1;
  end

  // FIFO storage; contents need no reset since rdata is gated by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= shreg;
  end

  // Pointers, occupancy and sticky flags; a new error beats a same-cycle clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_en)  wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      count       <= count_n;
      valid_q     <= (count_n != '0);
      overrun_q   <= drop     | (overrun_q   & ~bus.clr);
      frame_err_q <= ferr_set | (frame_err_q & ~bus.clr);
    end
  end

  assign bus.rdata     = (count != '0) ? mem[rptr] : 8'h00;
  assign bus.valid     = valid_q;
  assign bus.count     = count;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Memory-mapped UART receiver: the input-side companion of the transmit-only UART on the CPU data bus in the 0xE000xxxx peripheral window. It synchronises the asynchronous serial line, recovers 8N1 frames by mid-bit sampling, and buffers received bytes in a small FIFO. The CPU drains the FIFO through a read strobe and polls the status flags.

## Interface

Parameters:
- CLKDIV, 434: clock cycles per bit (50 MHz / 115200). Legal range 8..65535.
- AW, 2: FIFO address width; depth = 2**AW entries.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous and active-low.
- rx  in  1  serial input, asynchronous to clk, idle high.
- re  in  1  read strobe, one cycle; pops the FIFO head.
- clr  in  1  one-cycle strobe; clears overrun and frame_err.
- rdata  out  8  FIFO head byte; 0x00 when empty.
- valid  out  1  FIFO non-empty.
- count  out  AW+1  FIFO occupancy, 0..2**AW.
- overrun  out  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: a frame had a low stop bit.

## Operation

- Synchroniser: rx passes through 2 flops. Flop reset value is 1. Everything below uses the synchronised signal rxs.
- Bit timer: 16-bit down-counter. Bit counter: 3 bits. Shift register: 8 bits, LSB first.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: on rxs == 0, load timer with CLKDIV/2 - 1 and go to START.
  - START: when timer reaches 0, sample rxs. If 1, it is a false start: return to IDLE with nothing recorded. If 0, load timer with CLKDIV - 1, clear the bit counter, and go to DATA.
  - DATA: when timer reaches 0, shift rxs into bit 7 (right shift) and reload CLKDIV - 1. After the 8th bit (bit counter == 7), go to STOP.
  - STOP: when timer reaches 0, sample rxs. If 1, push the byte. If 0, set frame_err and discard the byte. Go to IDLE in both cases.
- A new start bit is accepted the cycle after returning to IDLE. There is no wait for a line-high period.
- FIFO:
  - Circular buffer with AW-bit read and write pointers, which wrap naturally.
  - count is held separately.
  - rdata = mem[rptr] when count != 0, else 0x00.
- Push when count == 2**AW and no pop in the same cycle: byte dropped, overrun set, FIFO unchanged.
- Push and pop in the same cycle:
  - Both occur and count is unchanged.
  - This includes the full case, which does not set overrun.
  - From empty, the pop is ignored and the push occurs (count becomes 1).
- re with count == 0: ignored; pointers and count unchanged.
- clr together with a new error event in the same cycle: the event wins and the flag stays 1.
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE; pointers, count, timer, bit counter and shift register = 0.
  - overrun = frame_err = 0; synchroniser flops = 1.
  - Resulting outputs: rdata = 0x00, valid = 0, count = 0.
  - After reset is released, a partial frame still in progress on the line may be seen as a start bit. This is acceptable.

## Timing

- rx to rxs: 2 cycles.
- Start edge on rxs to start-bit sample: CLKDIV/2 cycles.
- Bit samples follow at CLKDIV-cycle intervals.
- The stop-bit sample occurs 9*CLKDIV + CLKDIV/2 cycles after the rxs falling edge.
- The push happens on the stop-sample edge. valid, count and rdata reflect the new byte in the following cycle.
- re pops on the rising edge where it is high. rdata shows the next entry (or 0x00) in the following cycle.
- All outputs are registered, except rdata, which is a combinational read of the head register/memory.

## Test plan

- CLKDIV=16, send 0x55 then 0xA3 back-to-back -> count=2, rdata=0x55; pulse re -> rdata=0xA3, count=1; pulse re -> valid=0, rdata=0x00.
- AW=2, send 0x01..0x05 with no reads -> count=4, overrun=1, reads return 0x01,0x02,0x03,0x04; clr -> overrun=0.
- Drive rx low for 5 cycles (less than CLKDIV/2 after the synchroniser), then high -> state returns to IDLE, count=0, no flags set.
- Send 0x7E with the stop bit driven low -> frame_err=1, count unchanged; then a valid 0x42 -> count=1, rdata=0x42, frame_err still 1.
- FIFO full (4 bytes), assert re on the same cycle as the push of byte 0x99 -> count stays 4, overrun=0, and 0x99 is read last.
- Assert reset_n low mid-DATA of byte 0xC3, release it, let the line idle, then send 0x3C -> after reset all outputs are 0; afterwards only 0x3C is received (count=1), with no partial byte.
